// File: rtl/editor_pkg.sv
// Shared field codes, BCD ranges and state encoding for the RTC field editor.
package editor_pkg;

  localparam int unsigned DATO_W = 8;
  localparam int unsigned DIR_W  = 4;
  localparam int unsigned N_DIR  = 16;
  localparam int unsigned HOLD_W = 24;

  localparam logic [DIR_W-1:0] CAMPO_SEG     = 4'd2;
  localparam logic [DIR_W-1:0] CAMPO_MIN     = 4'd3;
  localparam logic [DIR_W-1:0] CAMPO_HORA    = 4'd4;
  localparam logic [DIR_W-1:0] CAMPO_DIA     = 4'd5;
  localparam logic [DIR_W-1:0] CAMPO_MES     = 4'd6;
  localparam logic [DIR_W-1:0] CAMPO_ANIO    = 4'd7;
  localparam logic [DIR_W-1:0] CAMPO_TMR_S   = 4'd8;
  localparam logic [DIR_W-1:0] CAMPO_TMR_MIN = 4'd9;
  localparam logic [DIR_W-1:0] CAMPO_TMR_H   = 4'd10;

  localparam logic [DATO_W-1:0] BCD_MIN_0  = 8'h00;
  localparam logic [DATO_W-1:0] BCD_MIN_1  = 8'h01;
  localparam logic [DATO_W-1:0] BCD_MAX_MS = 8'h59;
  localparam logic [DATO_W-1:0] BCD_MAX_H  = 8'h23;
  localparam logic [DATO_W-1:0] BCD_MAX_D  = 8'h31;
  localparam logic [DATO_W-1:0] BCD_MAX_M  = 8'h12;
  localparam logic [DATO_W-1:0] BCD_MAX_A  = 8'h99;

  typedef enum logic [1:0] {IDLE, EDIT, FLUSH, REQ} estado_t;

  function automatic logic campo_valido(input logic [DIR_W-1:0] c);
    return (c >= CAMPO_SEG) && (c <= CAMPO_TMR_H);
  endfunction

  function automatic logic [DATO_W-1:0] campo_min(input logic [DIR_W-1:0] c);
    case (c)
      CAMPO_DIA, CAMPO_MES: return BCD_MIN_1;
      default:              return BCD_MIN_0;
    endcase
  endfunction

  function automatic logic [DATO_W-1:0] campo_max(input logic [DIR_W-1:0] c);
    case (c)
      CAMPO_SEG, CAMPO_MIN, CAMPO_TMR_S, CAMPO_TMR_MIN: return BCD_MAX_MS;
      CAMPO_HORA, CAMPO_TMR_H:                          return BCD_MAX_H;
      CAMPO_DIA:                                        return BCD_MAX_D;
      CAMPO_MES:                                        return BCD_MAX_M;
      CAMPO_ANIO:                                       return BCD_MAX_A;
      default:                                          return BCD_MIN_0;
    endcase
  endfunction

endpackage

// File: rtl/editor_campos_bcd_paso.sv
// Combinational two-digit BCD +/-1 with wrap between min and max.
module bcd_paso
  import editor_pkg::*;
(
  input  logic [DATO_W-1:0] valor,
  input  logic              subir,
  input  logic              bajar,
  input  logic [DATO_W-1:0] min,
  input  logic [DATO_W-1:0] max,
  output logic [DATO_W-1:0] nuevo
);

  always_comb begin
    nuevo = valor;
    if (subir && !bajar) begin
      if (valor >= max)
        nuevo = min;
      else if (valor[3:0] >= 4'd9)
        nuevo = {4'(valor[7:4] + 4'd1), 4'd0};
      else
        nuevo = {valor[7:4], 4'(valor[3:0] + 4'd1)};
    end else if (bajar && !subir) begin
      if (valor <= min)
        nuevo = max;
      else if (valor[3:0] == 4'd0)
        nuevo = {4'(valor[7:4] - 4'd1), 4'd9};
      else
        nuevo = {valor[7:4], 4'(valor[3:0] - 4'd1)};
    end
  end

endmodule

// File: rtl/editor_campos.sv
// BCD shadow editor for RTC clock/date/timer fields with dirty-field write-back.
// Optional button auto-repeat is compiled in with EDITOR_AUTOREPEAT_EN.
module editor_campos
  import editor_pkg::*;
#(
  parameter logic [HOLD_W-1:0] REP_DELAY = 24'd5_000_000,
  parameter logic [HOLD_W-1:0] REP_RATE  = 24'd1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              interr,
  input  logic [DIR_W-1:0]  puntero,
  input  logic              arriba,
  input  logic              abajo,
  input  logic              wr_en,
  input  logic [DIR_W-1:0]  wr_dir,
  input  logic [DATO_W-1:0] wr_dato,
  input  logic [DIR_W-1:0]  dir_vis,
  output logic [DATO_W-1:0] dato_vis,
  output logic              esc_req,
  output logic [DIR_W-1:0]  esc_dir,
  output logic [DATO_W-1:0] esc_dato,
  input  logic              esc_ack,
  output logic              listo
);

  estado_t            estado;
  logic [DATO_W-1:0]  campos [N_DIR];
  logic [N_DIR-1:0]   sucio;
  logic [DIR_W-1:0]   idx;
  logic               arr_prev;
  logic               aba_prev;

  logic               sub_arr_c;
  logic               sub_aba_c;
  logic               edita_c;
  logic               rep_arr_c;
  logic               rep_aba_c;
  logic               up_c;
  logic               down_c;
  logic               paso_c;
  logic [DATO_W-1:0]  nuevo_c;

  assign sub_arr_c = arriba & ~arr_prev;
  assign sub_aba_c = abajo & ~aba_prev;
  assign edita_c   = interr && (estado == EDIT) && campo_valido(puntero);

`ifdef EDITOR_AUTOREPEAT_EN
  logic [HOLD_W-1:0] hold_cnt;
  logic              repitiendo;
  logic [DIR_W-1:0]  punt_prev;
  logic              held_c;
  logic              tick_c;

  // One button held alone on an unchanged field keeps the hold counter running.
  assign held_c = edita_c && (arriba ^ abajo) && (puntero == punt_prev);
  assign tick_c = held_c && !(sub_arr_c || sub_aba_c) &&
                  (hold_cnt == (repitiendo ? REP_RATE : REP_DELAY));
  assign rep_arr_c = tick_c & arriba;
  assign rep_aba_c = tick_c & abajo;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt   <= '0;
      repitiendo <= 1'b0;
      punt_prev  <= '0;
    end else begin
      punt_prev <= puntero;
      if (!held_c) begin
        hold_cnt   <= '0;
        repitiendo <= 1'b0;
      end else if (sub_arr_c || sub_aba_c) begin
        hold_cnt   <= HOLD_W'(1);
        repitiendo <= 1'b0;
      end else if (tick_c) begin
        hold_cnt   <= HOLD_W'(1);
        repitiendo <= 1'b1;
      end else begin
        hold_cnt <= HOLD_W'(hold_cnt + HOLD_W'(1));
      end
    end
  end
`else
  logic unused_rep_cfg;
  assign unused_rep_cfg = ^{REP_DELAY, REP_RATE};
  assign rep_arr_c = 1'b0;
  assign rep_aba_c = 1'b0;
`endif

  assign up_c   = sub_arr_c | rep_arr_c;
  assign down_c = sub_aba_c | rep_aba_c;
  assign paso_c = edita_c && (up_c ^ down_c);

  bcd_paso u_paso (
    .valor (campos[puntero]),
    .subir (up_c),
    .bajar (down_c),
    .min   (campo_min(puntero)),
    .max   (campo_max(puntero)),
    .nuevo (nuevo_c)
  );

  // Button history and display read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      arr_prev <= 1'b0;
      aba_prev <= 1'b0;
      dato_vis <= '0;
    end else begin
      arr_prev <= arriba;
      aba_prev <= abajo;
      dato_vis <= campos[dir_vis];
    end
  end

  // Edit/flush state machine owning the shadow fields and dirty bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado   <= IDLE;
      idx      <= '0;
      sucio    <= '0;
      esc_req  <= 1'b0;
      esc_dir  <= '0;
      esc_dato <= '0;
      listo    <= 1'b0;
      for (int i = 0; i < int'(N_DIR); i++) campos[i] <= '0;
      campos[CAMPO_DIA] <= BCD_MIN_1;
      campos[CAMPO_MES] <= BCD_MIN_1;
    end else begin
      listo <= 1'b0;
      case (estado)
        IDLE: begin
          if (wr_en && campo_valido(wr_dir)) begin
            campos[wr_dir] <= wr_dato;
            sucio[wr_dir]  <= 1'b0;
          end
          if (interr) estado <= EDIT;
        end
        EDIT: begin
          if (paso_c) begin
            campos[puntero] <= nuevo_c;
            sucio[puntero]  <= 1'b1;
          end
          if (!interr) begin
            estado <= FLUSH;
            idx    <= CAMPO_SEG;
          end
        end
        FLUSH: begin
          if (sucio[idx]) begin
            estado   <= REQ;
            esc_req  <= 1'b1;
            esc_dir  <= idx;
            esc_dato <= campos[idx];
          end else if (idx == CAMPO_TMR_H) begin
            estado <= IDLE;
            listo  <= 1'b1;
          end else begin
            idx <= DIR_W'(idx + DIR_W'(1));
          end
        end
        REQ: begin
          if (esc_ack) begin
            esc_req    <= 1'b0;
            sucio[idx] <= 1'b0;
            if (idx == CAMPO_TMR_H) begin
              estado <= IDLE;
              listo  <= 1'b1;
            end else begin
              estado <= FLUSH;
              idx    <= DIR_W'(idx + DIR_W'(1));
            end
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule
